// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forwarding-select encodings and the
// multi-cycle divide FSM state type.
// No ports; imported by hazard_unit and hazard_unit_div_stall_fsm.
package hazard_unit_pkg;

  // E-stage operand source select
  localparam logic [1:0] FWD_REG = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // forwarded from writeback
  localparam logic [1:0] FWD_MEM = 2'b10;  // forwarded from memory stage

  // Multi-cycle divide/multiply handshake states
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/hazard_unit_div_stall_fsm.sv
// Handshake FSM that freezes the pipe while a multi-cycle divide/multiply sits in E.
// Ports: i_clk/i_rst_n; i_divop (op in E), i_div_ready (result pulse), i_except_flush;
//   o_busy_stall (hold F/D/E this cycle), o_div_start/o_div_cancel/o_div_timeout pulses, o_div_busy.
module hazard_unit_div_stall_fsm
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W       = 6,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_divop,
  input  logic i_div_ready,
  input  logic i_except_flush,
  output logic o_busy_stall,
  output logic o_div_start,
  output logic o_div_cancel,
  output logic o_div_busy,
  output logic o_div_timeout
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DIV_TIMEOUT - 1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_busy;
  logic w_start;
  logic w_expire;
  logic w_hold;

  assign w_busy  = (r_state == S_BUSY);
  // Start is Mealy so the pipe freezes in the same cycle the op reaches E.
  assign w_start = (r_state == S_IDLE) && i_divop && !i_except_flush;
  // Exception flush outranks both the watchdog and a coincident result.
  assign w_expire = w_busy && !i_except_flush && !i_div_ready && (r_cnt == LP_LAST);
  assign w_hold   = w_busy && !i_except_flush && !i_div_ready && !w_expire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_start) r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (w_hold) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy_stall  = w_start || w_hold;
  assign o_div_start   = w_start;
  assign o_div_cancel  = (w_busy && i_except_flush) || w_expire;
  assign o_div_timeout = w_expire;
  assign o_div_busy    = w_busy;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard resolver for the 5-stage MIPS core: forwarding selects, load-use and
// branch stalls, exception flush, and the multi-cycle divide freeze (via the FSM sub-module).
// Ports: stage register indices/control bits in; forward selects, stall/flush, divider handshake out.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 6,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [REG_W-1:0] i_rsD,
  input  logic [REG_W-1:0] i_rtD,
  input  logic [REG_W-1:0] i_rsE,
  input  logic [REG_W-1:0] i_rtE,
  input  logic [REG_W-1:0] i_writeregE,
  input  logic [REG_W-1:0] i_writeregM,
  input  logic [REG_W-1:0] i_writeregW,
  input  logic             i_regwriteE,
  input  logic             i_regwriteM,
  input  logic             i_regwriteW,
  input  logic             i_memtoregE,
  input  logic             i_memtoregM,
  input  logic             i_branchD,
  input  logic             i_jrD,
  input  logic             i_divopE,
  input  logic             i_div_ready,
  input  logic             i_except_flush,
  output logic             o_forwardAD,
  output logic             o_forwardBD,
  output logic [1:0]       o_forwardAE,
  output logic [1:0]       o_forwardBE,
  output logic             o_stallF,
  output logic             o_stallD,
  output logic             o_stallE,
  output logic             o_stallM,
  output logic             o_stallW,
  output logic             o_flushE,
  output logic             o_flushM,
  output logic             o_flushW,
  output logic             o_div_start,
  output logic             o_div_cancel,
  output logic             o_div_busy,
  output logic             o_div_timeout
);

  logic w_busy_stall;
  logic w_div_start;
  logic w_div_cancel;
  logic w_div_busy;
  logic w_div_timeout;

  hazard_unit_div_stall_fsm #(
    .CNT_W      (CNT_W),
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) u_div_fsm (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_divop       (i_divopE),
    .i_div_ready   (i_div_ready),
    .i_except_flush(i_except_flush),
    .o_busy_stall  (w_busy_stall),
    .o_div_start   (w_div_start),
    .o_div_cancel  (w_div_cancel),
    .o_div_busy    (w_div_busy),
    .o_div_timeout (w_div_timeout)
  );

  // Register 0 is hardwired zero, so it never creates a dependency.
  logic w_mE_rs, w_mE_rt, w_wE_rs, w_wE_rt;
  logic w_mD_rs, w_mD_rt;
  logic w_eD_hit, w_lM_hit;
  logic w_lwstall, w_brstall;

  assign w_mE_rs = i_regwriteM && (i_writeregM != '0) && (i_writeregM == i_rsE);
  assign w_mE_rt = i_regwriteM && (i_writeregM != '0) && (i_writeregM == i_rtE);
  assign w_wE_rs = i_regwriteW && (i_writeregW != '0) && (i_writeregW == i_rsE);
  assign w_wE_rt = i_regwriteW && (i_writeregW != '0) && (i_writeregW == i_rtE);
  assign w_mD_rs = i_regwriteM && (i_writeregM != '0) && (i_writeregM == i_rsD);
  assign w_mD_rt = i_regwriteM && (i_writeregM != '0) && (i_writeregM == i_rtD);

  assign w_eD_hit = i_regwriteE && (i_writeregE != '0) &&
                    ((i_writeregE == i_rsD) || (i_writeregE == i_rtD));
  assign w_lM_hit = i_memtoregM && (i_writeregM != '0) &&
                    ((i_writeregM == i_rsD) || (i_writeregM == i_rtD));

  assign w_lwstall = i_memtoregE && (i_rtE != '0) && ((i_rtE == i_rsD) || (i_rtE == i_rtD));
  assign w_brstall = (i_branchD || i_jrD) && (w_eD_hit || w_lM_hit);

  logic [1:0] w_fwd_ae, w_fwd_be;
  logic       w_stall_f, w_stall_d, w_stall_e, w_flush_e, w_flush_m;

  always_comb begin
    w_fwd_ae = w_mE_rs ? FWD_MEM : (w_wE_rs ? FWD_WB : FWD_REG);
    w_fwd_be = w_mE_rt ? FWD_MEM : (w_wE_rt ? FWD_WB : FWD_REG);
  end

  // Priority: exception flush > divide freeze > load-use/branch stall.
  // Hazards are ignored for the whole time the FSM is BUSY (including the
  // release cycle); E still holds the divide then, and any pending D hazard is
  // re-evaluated once the FSM is back in IDLE.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_flush_e = 1'b0;
    w_flush_m = 1'b0;
    if (i_except_flush) begin
      w_flush_e = 1'b1;
      w_flush_m = 1'b1;
    end else if (w_busy_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_flush_m = 1'b1;
    end else if (!w_div_busy && (w_lwstall || w_brstall)) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  // Every output is forced low while reset is held, including the
  // combinational forwarding paths.
  assign o_forwardAD   = i_rst_n && w_mD_rs;
  assign o_forwardBD   = i_rst_n && w_mD_rt;
  assign o_forwardAE   = i_rst_n ? w_fwd_ae : FWD_REG;
  assign o_forwardBE   = i_rst_n ? w_fwd_be : FWD_REG;
  assign o_stallF      = i_rst_n && w_stall_f;
  assign o_stallD      = i_rst_n && w_stall_d;
  assign o_stallE      = i_rst_n && w_stall_e;
  assign o_flushE      = i_rst_n && w_flush_e;
  assign o_flushM      = i_rst_n && w_flush_m;
  assign o_div_start   = i_rst_n && w_div_start;
  assign o_div_cancel  = i_rst_n && w_div_cancel;
  assign o_div_busy    = i_rst_n && w_div_busy;
  assign o_div_timeout = i_rst_n && w_div_timeout;

  // Reserved stage controls.
  assign o_stallM = 1'b0;
  assign o_stallW = 1'b0;
  assign o_flushW = 1'b0;

endmodule
